// File: rtl/affine_converter.sv
// affine_converter
// Converts a projective point (X, Y, Z) over GF(2^255 - 19) into affine form
// (X/Z, Y/Z). Z^-1 comes from an external inverse block. The two final
// products are formed by an interleaved MSB-first bit-serial modular
// multiplier.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               one-cycle request, sampled only when idle
//   i_x, i_y, i_z         projective coordinates, sampled with i_start
//   o_busy                high whenever not idle
//   o_inv_start, o_inv_x  inverse request pulse and operand (reduced Z)
//   i_inv_result          Z^-1 mod N from the inverse block
//   i_inv_finished        one-cycle completion pulse from the inverse block
//   o_x, o_y              affine result
//   o_valid, o_err        result pulse; o_err flags Z == 0 (no inverse)
//
// state      | meaning
// S_IDLE     | waiting for i_start; captures and reduces the inputs
// S_INV_REQ  | issue the inverse request for Z
// S_INV_WAIT | wait for i_inv_finished, latch Z^-1 into b
// S_MUL_X    | acc = X * b mod N, 255 serial iterations
// S_MUL_Y    | acc = Y * b mod N, 255 serial iterations
// S_DONE     | raise o_valid for one cycle
module affine_converter #(
  parameter int W = 255,
  parameter logic [W-1:0] N = 255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic         o_busy,
  output logic         o_inv_start,
  output logic [W-1:0] o_inv_x,
  input  logic [W-1:0] i_inv_result,
  input  logic         i_inv_finished,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_valid,
  output logic         o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INV_REQ, S_INV_WAIT, S_MUL_X, S_MUL_Y, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] x_r, y_r, z_r, b_r, acc, acc_nxt, z_red;
  logic [7:0]   cnt;
  logic         err_r, z_zero, mul_bit, inv_start_d, valid_d;
  logic [W+1:0] dbl, sum;
  logic [W+1:0] n_ext;

  // Inputs are below 2N, so one conditional subtraction fully reduces them.
  function automatic logic [W-1:0] reduce(input logic [W-1:0] v);
    reduce = (v >= N) ? v - N : v;
  endfunction

  assign z_red   = reduce(i_z);
  assign z_zero  = (z_red == '0);
  assign o_inv_x = z_r;
  assign n_ext   = {2'b00, N};

  // One multiplier iteration: acc <- 2*acc (+ b) mod N, kept below N.
  always_comb begin
    mul_bit = (state == S_MUL_Y) ? y_r[cnt] : x_r[cnt];
    dbl = {1'b0, acc, 1'b0};
    if (dbl >= n_ext) dbl = dbl - n_ext;
    sum = dbl + (mul_bit ? {2'b00, b_r} : '0);
    acc_nxt = (sum >= n_ext) ? W'(sum - n_ext) : W'(sum);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_start) state_nxt = z_zero ? S_DONE : S_INV_REQ;
      S_INV_REQ:  state_nxt = S_INV_WAIT;
      S_INV_WAIT: if (i_inv_finished) state_nxt = S_MUL_X;
      S_MUL_X:    if (cnt == 8'd0) state_nxt = S_MUL_Y;
      S_MUL_Y:    if (cnt == 8'd0) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Pulse outputs are registered, so they appear one cycle after the state
  // that requests them.
  always_comb begin
    o_busy      = (state != S_IDLE);
    inv_start_d = (state == S_INV_REQ);
    valid_d     = (state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      cnt         <= '0;
      err_r       <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_inv_start <= 1'b0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_inv_start <= inv_start_d;
      o_valid     <= valid_d;
      o_err       <= valid_d & err_r;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            x_r   <= reduce(i_x);
            y_r   <= reduce(i_y);
            z_r   <= z_red;
            err_r <= z_zero;
            if (z_zero) begin
              o_x <= '0;
              o_y <= '0;
            end
          end
        end
        S_INV_WAIT: begin
          if (i_inv_finished) begin
            b_r <= i_inv_result;
            acc <= '0;
            cnt <= 8'(W - 1);
          end
        end
        S_MUL_X, S_MUL_Y: begin
          if (cnt == 8'd0) begin
            if (state == S_MUL_X) o_x <= acc_nxt;
            else                  o_y <= acc_nxt;
            acc <= '0;
            cnt <= 8'(W - 1);
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_converter.sv
module tb_affine_converter;

  localparam logic [254:0] NM = 255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;

  logic         i_clk = 1'b0;
  logic         i_rst_n, i_start, i_inv_finished;
  logic [254:0] i_x, i_y, i_z, i_inv_result;
  logic         o_busy, o_inv_start, o_valid, o_err;
  logic [254:0] o_inv_x, o_x, o_y;

  affine_converter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .o_busy(o_busy), .o_inv_start(o_inv_start), .o_inv_x(o_inv_x),
    .i_inv_result(i_inv_result), .i_inv_finished(i_inv_finished),
    .o_x(o_x), .o_y(o_y), .o_valid(o_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [254:0] x;
    logic [254:0] y;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_inv_start = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [254:0] red(input logic [254:0] v);
    logic [255:0] r;
    r = {1'b0, v} % {1'b0, NM};
    return r[254:0];
  endfunction

  function automatic logic [254:0] modmul(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] p;
    p = ({257'b0, a} * {257'b0, b}) % {257'b0, NM};
    return p[254:0];
  endfunction

  always @(negedge i_clk) if (o_inv_start) n_inv_start++;

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("o_x", o_x, e.x);
        check("o_y", o_y, e.y);
        check("o_err", o_err, e.err);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_inv_start"}, o_inv_start, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_inv_x"}, o_inv_x, 0);
  endtask

  // mode 0: plain conversion, 1: stray start/finished in S_MUL_X,
  // 2: reset asserted in the middle of S_MUL_Y
  task automatic convert(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                         input logic [254:0] inv, input int mode);
    logic [254:0] zr;
    exp_t e;
    int base, k;
    bit seen;
    zr    = red(z);
    e.err = (zr == 0);
    e.x   = e.err ? '0 : modmul(red(x), inv);
    e.y   = e.err ? '0 : modmul(red(y), inv);
    base  = n_inv_start;
    @(negedge i_clk);
    i_x = x; i_y = y; i_z = z; i_start = 1'b1;
    sb.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
    i_x = '0; i_y = '0; i_z = '0;
    @(negedge i_clk);
    if (e.err) begin
      check("zero_valid", o_valid, 1);
      check("zero_err", o_err, 1);
      repeat (3) @(negedge i_clk);
      check("zero_no_inv", n_inv_start - base, 0);
      return;
    end
    check("inv_start", o_inv_start, 1);
    check("inv_x", o_inv_x, zr);
    repeat (3) @(negedge i_clk);
    i_inv_result = inv;
    i_inv_finished = 1'b1;
    @(negedge i_clk);
    i_inv_finished = 1'b0;
    i_inv_result = '1;
    k = 0;
    seen = 1'b0;
    while (k < 600) begin
      if (o_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge i_clk);
      k++;
      if (mode == 1 && k == 100) begin
        i_start = 1'b1; i_inv_finished = 1'b1;
        i_x = 255'd77; i_y = 255'd88; i_z = 255'd3; i_inv_result = 255'd3;
      end
      if (mode == 1 && k == 101) begin
        i_start = 1'b0; i_inv_finished = 1'b0;
      end
      if (mode == 2 && k == 300) begin
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_inv_result = inv;
        i_inv_finished = 1'b1;
        @(negedge i_clk);
        i_inv_finished = 1'b0;
        check("late_finished_busy", o_busy, 0);
        @(negedge i_clk);
        check("late_finished_valid", o_valid, 0);
        return;
      end
    end
    check("valid_seen", seen, 1);
    if (seen) check("latency", k, 511);
    check("inv_once", n_inv_start - base, 1);
    @(negedge i_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] half1, half3;
    half1 = ({1'b0, NM} + 256'd1) >> 1;
    half3 = ({1'b0, NM} + 256'd3) >> 1;
    i_rst_n = 1'b0; i_start = 1'b0; i_inv_finished = 1'b0;
    i_x = '0; i_y = '0; i_z = '0; i_inv_result = '0;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;

    convert(255'd5, 255'd7, 255'd1, 255'd1, 0);
    check("basic_x", o_x, 5);
    check("basic_y", o_y, 7);

    convert(255'd2, 255'd3, 255'd2, half1[254:0], 0);
    check("half_x", o_x, 1);
    check("half_y", o_y, half3);

    convert(NM + 255'd1, NM, NM + 255'd1, 255'd1, 0);
    check("unred_x", o_x, 1);
    check("unred_y", o_y, 0);

    convert(255'd11, 255'd13, 255'd0, 255'd0, 0);
    convert(255'd11, 255'd13, NM, 255'd0, 0);
    check("zeroN_x", o_x, 0);

    convert(NM - 255'd5, 255'd12345, 255'd1, 255'd1, 1);
    check("stray_x", o_x, NM - 255'd5);

    convert(NM - 255'd2, 255'd3, 255'd2, half1[254:0], 2);

    convert(255'd9, 255'd4, 255'd1, 255'd1, 0);
    check("post_rst_x", o_x, 9);
    check("post_rst_y", o_y, 4);

    repeat (5) @(negedge i_clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
